mips_multicycle_controller: RTL

Control unit for the multicycle MIPS datapath, sitting directly upstream of `mips_alu`. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the ALU function select `F` (`alucontrol`) and all datapath mux and write-enable controls. It consumes the ALU zero flag `Z` to resolve branches.

---
 rtl/mips_multicycle_controller.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller
//   Moore-style control FSM for the multicycle MIPS datapath. Walks each
//   instruction through fetch / decode / execute / memory / writeback and
//   drives the ALU function select plus every datapath mux and enable.
//
// Ports
//   clk        in  1  rising-edge clock
//   reset      in  1  synchronous, active-low
//   op         in  6  instr[31:26]
//   funct      in  6  instr[5:0]
//   zero       in  1  ALU Z flag, used for beq
//   alucontrol out 3  ALU F (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   alusrca    out 1  0 = PC, 1 = register A
//   alusrcb    out 2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm << 2
//   pcsrc      out 2  00 ALU result, 01 ALUOut, 10 jump target
//   iord       out 1  memory address: 0 = PC, 1 = ALUOut
//   irwrite    out 1  instruction register write enable
//   memwrite   out 1  data memory write enable
//   regdst     out 1  0 = rt, 1 = rd
//   memtoreg   out 1  0 = ALUOut, 1 = memory data
//   regwrite   out 1  register file write enable
//   pcen       out 1  PC enable = pcwrite | (branch & zero)
//   state      out 4  current state (debug)

module mips_multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       pcen,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    state_t state_d;

    // Raw (pre-reset-gating) controls decoded from state.
    logic [2:0] alu_c;
    logic       asa_c;
    logic [1:0] asb_c;
    logic [1:0] pcs_c;
    logic       iord_c;
    logic       irw_c;
    logic       mw_c;
    logic       rd_c;
    logic       m2r_c;
    logic       rw_c;
    logic       pcwrite_c;
    logic       branch_c;
    logic [2:0] funct_alu;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    assign state = state_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW,
                    OP_SW:    state_d = MEMADR;
                    OP_RTYPE: state_d = EXECUTE;
                    OP_BEQ:   state_d = BRANCH;
                    OP_ADDI:  state_d = ADDIEX;
                    OP_J:     state_d = JUMP;
                    default:  state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_LW)
                    state_d = MEMRD;
                else if (op == OP_SW)
                    state_d = MEMWR;
                else
                    state_d = FETCH;
            end
            MEMRD:   state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = FETCH;
            EXECUTE: state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_c     = '0;
        asa_c     = 1'b0;
        asb_c     = '0;
        pcs_c     = '0;
        iord_c    = 1'b0;
        irw_c     = 1'b0;
        mw_c      = 1'b0;
        rd_c      = 1'b0;
        m2r_c     = 1'b0;
        rw_c      = 1'b0;
        pcwrite_c = 1'b0;
        branch_c  = 1'b0;
        case (state_q)
            FETCH: begin
                asb_c     = 2'b01;
                alu_c     = ALU_ADD;
                irw_c     = 1'b1;
                pcwrite_c = 1'b1;
            end
            DECODE: begin
                asb_c = 2'b11;
                alu_c = ALU_ADD;
            end
            MEMADR: begin
                asa_c = 1'b1;
                asb_c = 2'b10;
                alu_c = ALU_ADD;
            end
            MEMRD: begin
                iord_c = 1'b1;
            end
            MEMWB: begin
                m2r_c = 1'b1;
                rw_c  = 1'b1;
            end
            MEMWR: begin
                iord_c = 1'b1;
                mw_c   = 1'b1;
            end
            EXECUTE: begin
                asa_c = 1'b1;
                alu_c = funct_alu;
            end
            ALUWB: begin
                rd_c = 1'b1;
                rw_c = 1'b1;
            end
            BRANCH: begin
                asa_c    = 1'b1;
                alu_c    = ALU_SUB;
                pcs_c    = 2'b01;
                branch_c = 1'b1;
            end
            ADDIEX: begin
                asa_c = 1'b1;
                asb_c = 2'b10;
                alu_c = ALU_ADD;
            end
            ADDIWB: begin
                rw_c = 1'b1;
            end
            JUMP: begin
                pcs_c     = 2'b10;
                pcwrite_c = 1'b1;
            end
            default: ;
        endcase
    end

    // While reset is held the outputs present FETCH values with every
    // write enable forced low, whatever the state register still holds.
    always_comb begin
        if (!reset) begin
            alucontrol = ALU_ADD;
            alusrca    = 1'b0;
            alusrcb    = 2'b01;
            pcsrc      = 2'b00;
            iord       = 1'b0;
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            regwrite   = 1'b0;
            pcen       = 1'b0;
        end else begin
            alucontrol = alu_c;
            alusrca    = asa_c;
            alusrcb    = asb_c;
            pcsrc      = pcs_c;
            iord       = iord_c;
            irwrite    = irw_c;
            memwrite   = mw_c;
            regdst     = rd_c;
            memtoreg   = m2r_c;
            regwrite   = rw_c;
            pcen       = pcwrite_c | (branch_c & zero);
        end
    end

endmodule
